// File: rtl/ecp5_pll_phase_ctrl.sv
// rtl/ecp5_pll_phase_ctrl.sv - ECP5 EHXPLLL reset/lock sequencer and dynamic phase-step controller
// Optional LOAD state (PHASELOADREG pulse) enabled by defining PLL_PHASE_LOADREG_EN.
module ecp5_pll_phase_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_STABLE   = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETUP_CYCLES  = 2,
    parameter int STEP_HI       = 4,
    parameter int STEP_LO       = 4,
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_count,
    output logic             pll_rst,
    output logic [1:0]       phasesel,
    output logic             phasedir,
    output logic             phasestep,
    output logic             phaseloadreg,
    output logic             locked,
    output logic             busy,
    output logic             done,
    output logic             abort
);

    localparam int CMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CMAX_B = (SETUP_CYCLES > SETTLE_CYCLES) ? SETUP_CYCLES : SETTLE_CYCLES;
    localparam int CMAX_C = (STEP_HI > STEP_LO) ? STEP_HI : STEP_LO;
    localparam int CMAX_D = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
    localparam int CMAX   = (CMAX_D > CMAX_C) ? CMAX_D : CMAX_C;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int SW     = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_IDLE      = 3'd2,
        S_SETUP     = 3'd3,
        S_STEP_HI   = 3'd4,
        S_STEP_LO   = 3'd5,
`ifdef PLL_PHASE_LOADREG_EN
        S_LOAD      = 3'd6,
`endif
        S_SETTLE    = 3'd7
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [SW-1:0]    stab, stab_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic [1:0]       sel_q, sel_n;
    logic             dir_q, dir_n;
    logic [1:0]       sync_q;
    logic             lk;
    logic             active;

    // PLL LOCK is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    assign lk = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_PLL_RST;
            cnt   <= '0;
            stab  <= '0;
            rem   <= '0;
            sel_q <= 2'b00;
            dir_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            stab  <= stab_n;
            rem   <= rem_n;
            sel_q <= sel_n;
            dir_q <= dir_n;
        end
    end

    assign active = (state != S_PLL_RST) && (state != S_WAIT_LOCK);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stab_n  = stab;
        rem_n   = rem;
        sel_n   = sel_q;
        dir_n   = dir_q;
        done    = 1'b0;
        abort   = 1'b0;
        // Lock loss outranks any accept or completion in the same cycle
        if (active && !lk) begin
            abort   = 1'b1;
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
            stab_n  = '0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                        stab_n  = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    stab_n = lk ? stab + SW'(1) : '0;
                    if (lk && (stab == SW'(LOCK_STABLE - 1))) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                        stab_n  = '0;
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        state_n = S_PLL_RST;
                        cnt_n   = '0;
                        stab_n  = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        sel_n   = req_sel;
                        dir_n   = req_dir;
                        rem_n   = req_count;
                        cnt_n   = '0;
                        state_n = (req_count == '0) ? S_SETTLE : S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == CW'(SETUP_CYCLES - 1)) begin
                        state_n = S_STEP_HI;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_STEP_HI: begin
                    if (cnt == CW'(STEP_HI - 1)) begin
                        state_n = S_STEP_LO;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_STEP_LO: begin
                    if (cnt == CW'(STEP_LO - 1)) begin
                        cnt_n = '0;
                        rem_n = rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
`ifdef PLL_PHASE_LOADREG_EN
                            state_n = S_LOAD;
`else
                            state_n = S_SETTLE;
`endif
                        end else begin
                            state_n = S_STEP_HI;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
`ifdef PLL_PHASE_LOADREG_EN
                S_LOAD: begin
                    state_n = S_SETTLE;
                    cnt_n   = '0;
                end
`endif
                S_SETTLE: begin
                    if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                        done    = 1'b1;
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = S_PLL_RST;
                    cnt_n   = '0;
                    stab_n  = '0;
                end
            endcase
        end
    end

    // Gating by lk makes the abort cycle look like WAIT_LOCK on every other output
    assign pll_rst   = (state == S_PLL_RST);
    assign req_ready = (state == S_IDLE) && lk;
    assign locked    = active && lk;
    assign busy      = active && (state != S_IDLE) && lk;
    assign phasestep = (state == S_STEP_HI) && lk;
    assign phasesel  = sel_q;
    assign phasedir  = dir_q;
`ifdef PLL_PHASE_LOADREG_EN
    assign phaseloadreg = (state == S_LOAD) && lk;
`else
    assign phaseloadreg = 1'b0;
`endif

endmodule
